// File: rtl/tournament_selector.sv
// Tournament selection stage for a compact GA: keeps the lowest of TournamentSize
// samples, then pulses a write strobe with the winner and its derived update step.
module tournament_selector #(
  parameter int Width          = 32,
  parameter int TaxWidth       = 2,
  parameter int TournamentSize = 6,
  parameter int CountWidth     = 3,
  parameter int GenWidth       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [Width-1:0]      individual,
  input  logic [Width-1:0]      target,
  output logic [Width-1:0]      winner,
  output logic [TaxWidth-1:0]   tax,
  output logic                  we,
  output logic [GenWidth-1:0]   generation,
  output logic                  found,
  output logic [1:0]            dbg_state_o,
  output logic [CountWidth-1:0] dbg_count_o
);

  typedef enum logic [1:0] {
    S_SAMPLE = 2'd0,
    S_COMMIT = 2'd1,
    S_HALT   = 2'd2
  } state_t;

  localparam logic [CountWidth-1:0] LastCount = CountWidth'(TournamentSize - 1);

  state_t                state_q, state_d;
  logic [CountWidth-1:0] count_q, count_d;
  logic [Width-1:0]      winner_q, winner_d;
  logic [GenWidth-1:0]   generation_q, generation_d;
  logic                  found_q, found_d;
  logic                  we_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_SAMPLE;
      count_q      <= '0;
      winner_q     <= '0;
      generation_q <= '0;
      found_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      winner_q     <= winner_d;
      generation_q <= generation_d;
      found_q      <= found_d;
    end
  end

  // With ce low every register holds, so a pending commit simply waits.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    winner_d     = winner_q;
    generation_d = generation_q;
    found_d      = found_q;
    we_d         = 1'b0;
    if (ce) begin
      case (state_q)
        S_SAMPLE: begin
          // Strict less-than: ties keep the earlier sample.
          if (count_q == '0 || individual < winner_q) begin
            winner_d = individual;
          end
          if (count_q == LastCount) begin
            count_d = '0;
            state_d = S_COMMIT;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
        S_COMMIT: begin
          we_d = 1'b1;
          if (generation_q != '1) begin
            generation_d = generation_q + 1'b1;
          end
          if (winner_q <= target) begin
            found_d = 1'b1;
            state_d = S_HALT;
          end else begin
            state_d = S_SAMPLE;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  assign winner      = winner_q;
  assign tax         = ~winner_q[Width-2 -: TaxWidth];
  assign we          = we_d;
  assign generation  = generation_q;
  assign found       = found_q;
  assign dbg_state_o = state_q;
  assign dbg_count_o = count_q;

endmodule

// File: tb/tb_tournament_selector.sv
// Directed bench for tournament_selector: commit winners are queued at stimulus time
// and checked by an independent monitor whenever the write strobe is seen.
module tb_tournament_selector;

  localparam int Width = 32;
  localparam int TaxWidth = 2;
  localparam int GenWidth = 16;
  localparam int CountWidth = 3;

  logic                  clk;
  logic                  rst;
  logic                  ce;
  logic [Width-1:0]      individual;
  logic [Width-1:0]      target;
  logic [Width-1:0]      winner;
  logic [TaxWidth-1:0]   tax;
  logic                  we;
  logic [GenWidth-1:0]   generation;
  logic                  found;
  logic [1:0]            dbg_state;
  logic [CountWidth-1:0] dbg_count;

  tournament_selector #(
    .Width(Width), .TaxWidth(TaxWidth), .TournamentSize(6),
    .CountWidth(CountWidth), .GenWidth(GenWidth)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .individual(individual), .target(target),
    .winner(winner), .tax(tax), .we(we), .generation(generation), .found(found),
    .dbg_state_o(dbg_state), .dbg_count_o(dbg_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [Width-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  logic we_prev = 1'b0;
  logic [Width-1:0] smp [6];
  logic [Width-1:0] wexp [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // drivers
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [Width-1:0] ind);
    ce = 1'b1;
    individual = ind;
    cycle();
  endtask

  task automatic play();
    for (int i = 0; i < 6; i++) begin
      step(smp[i]);
      chk("winner_seq", 64'(winner), 64'(wexp[i]));
    end
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, "_winner"}, 64'(winner), 64'd0);
    chk({name, "_tax"}, 64'(tax), 64'd3);
    chk({name, "_we"}, 64'(we), 64'd0);
    chk({name, "_gen"}, 64'(generation), 64'd0);
    chk({name, "_found"}, 64'(found), 64'd0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (we) begin
      checks++;
      if (we_prev) begin
        errors++;
        $display("FAIL we_back_to_back: we high two cycles running at %0t", $time);
      end
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_we: got we=1 expected none, winner=%0h at %0t", winner, $time);
      end else begin
        chk("commit_winner", 64'(winner), 64'(exp_q.pop_front()));
      end
    end
    we_prev = we;
  end

  initial begin
    rst = 1'b0;
    ce = 1'b1;
    individual = 32'd123;
    target = '0;

    // reset held for two edges, then one idle cycle after release
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk_idle_outputs("reset");
    end
    rst = 1'b1;
    ce = 1'b0;
    cycle();
    chk_idle_outputs("post_reset");

    // basic tournament, never meets target 0
    smp  = '{32'd50, 32'd30, 32'd40, 32'd30, 32'd70, 32'd60};
    wexp = '{32'd50, 32'd30, 32'd30, 32'd30, 32'd30, 32'd30};
    exp_q.push_back(32'd30);
    play();
    chk("commit_state", 64'(dbg_state), 64'd1);
    chk("commit_we", 64'(we), 64'd1);
    step(32'd999);
    chk("gen_after_commit", 64'(generation), 64'd1);
    chk("we_after_commit", 64'(we), 64'd0);
    chk("found_after_commit", 64'(found), 64'd0);
    chk("winner_held_in_commit", 64'(winner), 64'd30);

    // new tournament: first sample overwrites, tax derived from bits [30:29]
    step(32'h4000_0000);
    chk("new_gen_winner", 64'(winner), 64'h4000_0000);
    chk("tax_4000", 64'(tax), 64'd1);
    step(32'h5000_0000);
    chk("winner_keep_lower", 64'(winner), 64'h4000_0000);
    step(32'h3000_0000);
    chk("winner_3rd", 64'(winner), 64'h3000_0000);
    chk("count_3rd", 64'(dbg_count), 64'd3);

    // stall in SAMPLE
    ce = 1'b0;
    individual = 32'd1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_winner", 64'(winner), 64'h3000_0000);
      chk("stall_count", 64'(dbg_count), 64'd3);
      chk("stall_we", 64'(we), 64'd0);
    end
    exp_q.push_back(32'h2000_0000);
    step(32'h3800_0000);
    step(32'h2000_0000);
    step(32'h2800_0000);
    chk("resume_state", 64'(dbg_state), 64'd1);
    chk("resume_winner", 64'(winner), 64'h2000_0000);
    chk("tax_2000", 64'(tax), 64'd2);

    // stall during COMMIT: pulse deferred, not lost
    ce = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #2;
      chk("commit_stall_we", 64'(we), 64'd0);
      cycle();
      chk("commit_stall_state", 64'(dbg_state), 64'd1);
      chk("commit_stall_gen", 64'(generation), 64'd1);
    end
    ce = 1'b1;
    #2;
    chk("commit_resume_we", 64'(we), 64'd1);
    cycle();
    chk("gen_two", 64'(generation), 64'd2);
    chk("state_sample_again", 64'(dbg_state), 64'd0);

    // reset while in COMMIT (strobe still seen in that cycle)
    smp  = '{32'd9, 32'd8, 32'd7, 32'd6, 32'd5, 32'd4};
    wexp = '{32'd9, 32'd8, 32'd7, 32'd6, 32'd5, 32'd4};
    exp_q.push_back(32'd4);
    play();
    rst = 1'b0;
    cycle();
    chk_idle_outputs("mid_commit_reset");
    chk("mid_commit_reset_count", 64'(dbg_count), 64'd0);
    chk("mid_commit_reset_state", 64'(dbg_state), 64'd0);
    rst = 1'b1;

    // halt on target
    target = 32'd100;
    smp  = '{32'd200, 32'd99, 32'd150, 32'd300, 32'd120, 32'd101};
    wexp = '{32'd200, 32'd99, 32'd99, 32'd99, 32'd99, 32'd99};
    exp_q.push_back(32'd99);
    play();
    step(32'd5);
    chk("halt_found", 64'(found), 64'd1);
    chk("halt_gen", 64'(generation), 64'd1);
    chk("halt_state", 64'(dbg_state), 64'd2);
    target = 32'd1000;
    for (int i = 0; i < 20; i++) begin
      ce = 1'($urandom_range(0, 1));
      individual = 32'($urandom_range(0, 50));
      cycle();
      chk("halt_we", 64'(we), 64'd0);
      chk("halt_winner", 64'(winner), 64'd99);
      chk("halt_gen_hold", 64'(generation), 64'd1);
      chk("halt_found_hold", 64'(found), 64'd1);
    end

    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tournament_selector.md
# tournament_selector

Tournament selection stage that sits directly downstream of the probability-vector population in the compact genetic algorithm. Each cycle it samples the population's `individual` output and tracks the fittest sample, where a lower unsigned value is fitter. After `TournamentSize` samples it drives `winner`, `tax` and a one-cycle `we` pulse back into the population. It counts generations and halts once a winner meets a programmable target.

## Interface
- `Width`, 32: individual width; must match the population.
- `TaxWidth`, 2: learning-step width; must match the population.
- `TournamentSize`, 6: samples per generation, ≥2.
- `CountWidth`, 3: sample counter width; 2^CountWidth ≥ TournamentSize.
- `GenWidth`, 16: generation counter width.

Ports:
- `clk`  in  1  single system clock; all logic on its rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `ce`  in  1  clock enable; when low all state holds.
- `individual`  in  Width  current sample from the population.
- `target`  in  Width  halt threshold; sampled only in COMMIT.
- `winner`  out  Width  running/final best sample (registered).
- `tax`  out  TaxWidth  update step derived from `winner`.
- `we`  out  1  population write strobe.
- `generation`  out  GenWidth  completed generations.
- `found`  out  1  a committed winner was ≤ `target`.

## Operation
- States: SAMPLE, COMMIT, HALT. Reset enters SAMPLE.
- Reset values: `winner` 0, `tax` = ~0[...] = all-ones, `we` 0, `generation` 0, `found` 0, `count` 0.
- SAMPLE, with `ce`=1, on each edge:
  - If `count`=0: `winner` ← `individual`.
  - Otherwise, if `individual` < `winner` (unsigned): `winner` ← `individual`. Ties keep the earlier sample.
  - `count` increments. When `count` = TournamentSize−1, the current sample is still evaluated, then `count` ← 0 and the state goes to COMMIT.
- COMMIT, lasting one `ce`-qualified cycle:
  - `we` = 1 (combinational: state==COMMIT & `ce`). `winner` and `tax` are stable for the whole cycle.
  - On the edge, `generation` increments, saturating at all-ones.
  - If `winner` ≤ `target`: `found` ← 1 and the state goes to HALT. Otherwise the state returns to SAMPLE.
- HALT: `we` = 0. `winner`, `tax`, `generation` and `found` hold until `rst`=0. `ce` has no effect.
- `tax` = bitwise NOT of `winner[Width-2 -: TaxWidth]`, a pure function of the registered `winner`. The MSB is excluded.
- `ce`=0 in any state:
  - No register changes.
  - `we` = 0. A pending commit is deferred, not lost; it fires in the first cycle `ce` returns to 1.
- `individual` is ignored outside SAMPLE. The population has already advanced during COMMIT, so samples taken after COMMIT come from the updated vector.

## Timing
- One sample per enabled cycle; no input handshake.
- Generation period is TournamentSize+1 enabled cycles (default 7).
- `winner` reflects the sample taken at edge k from edge k onward.
- Final `winner` is valid from the edge that enters COMMIT.
- `we` is high for exactly one enabled cycle per generation. It is never asserted on two consecutive cycles.
- `generation` and `found` update on the edge that ends COMMIT.
- `rst`=0 has priority over `ce` and over any state, including mid-COMMIT: `we` drops in the cycle after the reset edge, `count` returns to 0, and no generation is counted.
- Simultaneous `rst`=0 and `ce`=0: reset wins.

## Test plan
- Reset: hold `rst`=0 for 2 edges with `ce`=1. Required: `winner`=0, `tax`=2'b11, `we`=0, `generation`=0, `found`=0 throughout and one cycle after release.
- Tournament: `target`=0; samples 50, 30, 40, 30, 70, 60 on consecutive enabled edges. Required:
  - `winner` sequence 50, 30, 30, 30, 30, 30.
  - `we`=1 for exactly the next cycle.
  - `generation` = 1 after that edge.
  - The 7th cycle is a new sample with `winner` ← that sample.
- Tax: winner 32'h4000_0000. Required: `tax`=2'b01, since bits[30:29]=2'b10.
- Stall: drop `ce` for 3 cycles after the 3rd sample with `individual`=1. Required: `winner` and `count` unchanged, and `we` never asserts. Resuming completes the tournament after 3 more samples. Also drop `ce` during COMMIT: `we`=0 while `ce` is low, and the pulse is delivered on resume.
- Halt: `target`=100; samples 200, 99, 150, 300, 120, 101. Required: COMMIT with `winner`=99, then `found`=1 and `generation`=1. No further `we` for 20 cycles; outputs are frozen.
- Reset mid-COMMIT: assert `rst`=0 in the COMMIT cycle. Required: `generation` stays 0, `we`=0 on the next cycle, and a clean new tournament follows release.
